// File: rtl/msfsm_sm_component.sv
// Single-token state-machine component for MSFSM decompositions of free-choice Petri nets.
// Exactly one place is marked; one enabled transition fires per cycle, chosen by fixed priority or round-robin.
module msfsm_sm_component #(
    parameter int NPLACE     = 8,
    parameter int NTRANS     = 8,
    parameter int INIT_PLACE = 0,
    parameter logic [NTRANS*$clog2(NPLACE)-1:0] PRE_MAP  = '0,
    parameter logic [NTRANS*$clog2(NPLACE)-1:0] POST_MAP = '0,
    parameter int ARB_MODE   = 0,
    parameter int DL_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              load,
    input  logic [NPLACE-1:0] d,
    input  logic [NTRANS-1:0] t_req,
    input  logic [NTRANS-1:0] t_guard,
    output logic [NPLACE-1:0] place,
    output logic [NTRANS-1:0] t_enabled,
    output logic [NTRANS-1:0] t_fire,
    output logic              deadlock,
    output logic              load_err
);
    localparam int PW  = $clog2(NPLACE);
    localparam int TW  = (NTRANS > 1) ? $clog2(NTRANS) : 1;
    localparam int TW1 = TW + 1;
    localparam int CW  = $clog2(DL_TIMEOUT + 1);

    localparam logic [NPLACE-1:0] ONE_P   = 1;
    localparam logic [NTRANS-1:0] ONE_T   = 1;
    localparam logic [NPLACE-1:0] INIT_OH = ONE_P << INIT_PLACE;
    localparam logic [TW-1:0]     LAST_T  = TW'(NTRANS - 1);
    localparam logic [CW-1:0]     DL_MAX  = CW'(DL_TIMEOUT);

    logic [NPLACE-1:0] place_q, place_d;
    logic [NTRANS-1:0] fire_q, fire_d;
    logic [TW-1:0]     ptr_q, ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              dl_q, dl_d;
    logic              lerr_q, lerr_d;

    logic [NTRANS-1:0] req_pre;
    logic [NPLACE-1:0] post_oh [NTRANS];
    logic [TW-1:0]     win;
    logic              found;
    logic              blocked;
    logic [TW1-1:0]    cand;

    if (INIT_PLACE < 0 || INIT_PLACE >= NPLACE) begin : g_init_err
        $error("msfsm_sm_component: INIT_PLACE %0d out of range", INIT_PLACE);
    end

    // Per-transition decode of the pre/post maps; a bad index disables the transition.
    for (genvar gi = 0; gi < NTRANS; gi++) begin : g_trans
        localparam int PRE  = int'(PRE_MAP[gi*PW +: PW]);
        localparam int POST = int'(POST_MAP[gi*PW +: PW]);

        if (PRE >= NPLACE || POST >= NPLACE) begin : g_cfg_err
            $error("msfsm_sm_component: transition %0d maps to place >= NPLACE", gi);
        end

        if (PRE < NPLACE) begin : g_pre
            assign req_pre[gi] = place_q[PRE] & t_req[gi];
        end else begin : g_pre_bad
            assign req_pre[gi] = 1'b0;
        end

        assign post_oh[gi] = ONE_P << POST;
    end

    assign t_enabled = req_pre & t_guard;

    // Candidate scan: from 0 in fixed-priority mode, from the pointer with wrap in round-robin mode.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int i = 0; i < NTRANS; i++) begin
            if (ARB_MODE == 0) begin
                cand = TW1'(i);
            end else begin
                cand = {1'b0, ptr_q} + TW1'(i);
                if (cand >= TW1'(NTRANS)) begin
                    cand = cand - TW1'(NTRANS);
                end
            end
            if (!found && t_enabled[cand[TW-1:0]]) begin
                found = 1'b1;
                win   = cand[TW-1:0];
            end
        end
    end

    // Blocked: a requested transition has its pre-place marked but its external guard is low.
    assign blocked = en & ~load & (|req_pre) & ~found;

    always_comb begin
        place_d = place_q;
        fire_d  = '0;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        dl_d    = dl_q;
        lerr_d  = lerr_q;
        if (en) begin
            dl_d = (cnt_q == DL_MAX);
            if (load) begin
                cnt_d = '0;
                if ($onehot(d)) begin
                    place_d = d;
                    lerr_d  = 1'b0;
                end else begin
                    lerr_d  = 1'b1;
                end
            end else if (found) begin
                place_d = post_oh[win];
                fire_d  = ONE_T << win;
                cnt_d   = '0;
                if (ARB_MODE == 1) begin
                    ptr_d = (win == LAST_T) ? '0 : win + 1'b1;
                end
            end else if (blocked) begin
                if (cnt_q != DL_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            place_q <= INIT_OH;
            fire_q  <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            dl_q    <= 1'b0;
            lerr_q  <= 1'b0;
        end else begin
            place_q <= place_d;
            fire_q  <= fire_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            dl_q    <= dl_d;
            lerr_q  <= lerr_d;
        end
    end

    assign place    = place_q;
    assign t_fire   = fire_q;
    assign deadlock = dl_q;
    assign load_err = lerr_q;

endmodule

// File: tb/tb_msfsm_sm_component.sv
// Bench for msfsm_sm_component: fixed-priority and round-robin instances share stimulus
// and are checked every cycle against a place-index reference model of the net rules.
module tb_msfsm_sm_component;
    localparam int DLT = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b1;
    logic       load = 1'b0;
    logic [3:0] d = 4'b0;
    logic [3:0] t_req = 4'b0;
    logic [3:0] t_guard = 4'b0;

    logic [3:0] place_fp, ten_fp, fire_fp;
    logic [3:0] place_rr, ten_rr, fire_rr;
    logic       dl_fp, lerr_fp, dl_rr, lerr_rr;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Net: t0 p0->p1, t1 p0->p2, t2 p1->p3, t3 p3->p0
    int pre_m  [4] = '{0, 0, 1, 3};
    int post_m [4] = '{1, 2, 3, 0};

    // Reference state per instance: 0 = fixed priority, 1 = round-robin
    int m_place [2];
    int m_ptr   [2];
    int m_cnt   [2];
    int m_fire  [2];
    bit m_dl    [2];
    bit m_lerr  [2];

    always #5 clk = ~clk;

    msfsm_sm_component #(
        .NPLACE(4), .NTRANS(4), .INIT_PLACE(0),
        .PRE_MAP(8'b11_01_00_00), .POST_MAP(8'b00_11_10_01),
        .ARB_MODE(0), .DL_TIMEOUT(DLT)
    ) u_fp (
        .clk(clk), .reset(reset), .en(en), .load(load), .d(d),
        .t_req(t_req), .t_guard(t_guard), .place(place_fp),
        .t_enabled(ten_fp), .t_fire(fire_fp), .deadlock(dl_fp), .load_err(lerr_fp)
    );

    msfsm_sm_component #(
        .NPLACE(4), .NTRANS(4), .INIT_PLACE(0),
        .PRE_MAP(8'b11_01_00_00), .POST_MAP(8'b00_11_10_01),
        .ARB_MODE(1), .DL_TIMEOUT(DLT)
    ) u_rr (
        .clk(clk), .reset(reset), .en(en), .load(load), .d(d),
        .t_req(t_req), .t_guard(t_guard), .place(place_rr),
        .t_enabled(ten_rr), .t_fire(fire_rr), .deadlock(dl_rr), .load_err(lerr_rr)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, act, exp);
        end
    endtask

    function automatic int model_en(input int i);
        int r = 0;
        for (int k = 0; k < 4; k++)
            if (pre_m[k] == m_place[i] && t_req[k] && t_guard[k]) r |= (1 << k);
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_place[i] = 0; m_ptr[i] = 0; m_cnt[i] = 0;
            m_fire[i] = 0;  m_dl[i] = 0;  m_lerr[i] = 0;
        end
    endtask

    task automatic model_step(input int i);
        int ena, w, idx;
        bit blk;
        ena = model_en(i);
        blk = 0;
        for (int k = 0; k < 4; k++)
            if (t_req[k] && pre_m[k] == m_place[i]) blk = 1;
        m_fire[i] = 0;
        if (en) begin
            m_dl[i] = (m_cnt[i] == DLT);
            if (load) begin
                m_cnt[i] = 0;
                if ($countones(d) == 1) begin
                    for (int k = 0; k < 4; k++) if (d[k]) m_place[i] = k;
                    m_lerr[i] = 0;
                end else begin
                    m_lerr[i] = 1;
                end
            end else if (ena != 0) begin
                w = -1;
                for (int j = 0; j < 4; j++) begin
                    idx = (i == 0) ? j : (m_ptr[i] + j) % 4;
                    if (w < 0 && ena[idx]) w = idx;
                end
                m_place[i] = post_m[w];
                m_fire[i]  = 1 << w;
                if (i == 1) m_ptr[i] = (w + 1) % 4;
                m_cnt[i] = 0;
            end else if (blk) begin
                m_cnt[i] = (m_cnt[i] < DLT) ? m_cnt[i] + 1 : DLT;
            end else begin
                m_cnt[i] = 0;
            end
        end
    endtask

    task automatic compare_all();
        check_eq("place_fp", place_fp, 1 << m_place[0]);
        check_eq("place_rr", place_rr, 1 << m_place[1]);
        check_eq("fire_fp", fire_fp, m_fire[0]);
        check_eq("fire_rr", fire_rr, m_fire[1]);
        check_eq("dl_fp", dl_fp, m_dl[0]);
        check_eq("dl_rr", dl_rr, m_dl[1]);
        check_eq("lerr_fp", lerr_fp, m_lerr[0]);
        check_eq("lerr_rr", lerr_rr, m_lerr[1]);
        check_eq("en_fp", ten_fp, model_en(0));
        check_eq("en_rr", ten_rr, model_en(1));
    endtask

    task automatic tick();
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
        cyc++;
        compare_all();
        $display("cyc %0d en=%b ld=%b d=%b req=%b grd=%b | place %b/%b fire %b/%b dl %b/%b lerr %b/%b",
                 cyc, en, load, d, t_req, t_guard, place_fp, place_rr, fire_fp, fire_rr,
                 dl_fp, dl_rr, lerr_fp, lerr_rr);
    endtask

    // Reset is raised between edges so its effect must be immediate.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        check_eq("rst_place_fp", place_fp, 4'b0001);
        check_eq("rst_place_rr", place_rr, 4'b0001);
        check_eq("rst_fire_fp", fire_fp, 4'b0000);
        check_eq("rst_dl_fp", dl_fp, 1'b0);
        check_eq("rst_lerr_rr", lerr_rr, 1'b0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        compare_all();
    endtask

    task automatic load_place(input logic [3:0] v);
        en = 1'b1; load = 1'b1; d = v;
        tick();
        load = 1'b0;
    endtask

    logic [3:0] rr_exp [3];

    initial begin
        rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0001;
        model_reset();
        do_reset();

        // Basic firing and one-cycle pulse
        t_guard = 4'b1111; t_req = 4'b0001;
        tick();
        check_eq("s1_place", place_fp, 4'b0010);
        check_eq("s1_fire", fire_fp, 4'b0001);
        t_req = 4'b0000;
        tick();
        check_eq("s1_pulse_end", fire_fp, 4'b0000);
        t_req = 4'b0100;
        tick();
        check_eq("s1_place2", place_fp, 4'b1000);
        check_eq("s1_fire2", fire_fp, 4'b0100);
        t_req = 4'b0000;
        tick();

        // Conflict arbitration, fresh pointer
        do_reset();
        for (int r = 0; r < 3; r++) begin
            t_req = 4'b0000;
            load_place(4'b0001);
            t_req = 4'b0011;
            tick();
            check_eq("s2_fp_win", fire_fp, 4'b0001);
            check_eq("s3_rr_win", fire_rr, rr_exp[r]);
        end
        t_req = 4'b0000;
        tick();

        // Guard-blocked deadlock and recovery
        load_place(4'b0001);
        t_req = 4'b0001; t_guard = 4'b0000;
        repeat (5) tick();
        check_eq("s4_dl_set", dl_fp, 1'b1);
        t_guard = 4'b0001;
        tick();
        check_eq("s4_fire", fire_fp, 4'b0001);
        tick();
        check_eq("s4_dl_clr", dl_fp, 1'b0);

        // Illegal and legal loads, load beats firing
        t_req = 4'b0000; t_guard = 4'b1111;
        load_place(4'b0110);
        check_eq("s5_lerr", lerr_fp, 1'b1);
        check_eq("s5_hold", place_fp, 4'b0010);
        load_place(4'b1000);
        check_eq("s5_lerr_clr", lerr_fp, 1'b0);
        check_eq("s5_place", place_fp, 4'b1000);
        t_req = 4'b1000;
        load_place(4'b0001);
        check_eq("s5_nofire", fire_fp, 4'b0000);

        // Enable low holds everything including the stall counter
        t_req = 4'b0001; t_guard = 4'b0000;
        repeat (2) tick();
        en = 1'b0; t_guard = 4'b1111;
        repeat (5) tick();
        check_eq("s6_hold_place", place_fp, 4'b0001);
        check_eq("s6_hold_fire", fire_fp, 4'b0000);
        en = 1'b1; t_guard = 4'b0000;
        repeat (2) tick();
        t_guard = 4'b1111;
        tick();
        check_eq("s6_moved", place_fp, 4'b0010);
        do_reset();

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            en      = ($urandom_range(0, 7) != 0);
            load    = ($urandom_range(0, 9) == 0);
            d       = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'(1 << $urandom_range(0, 3));
            t_req   = 4'($urandom);
            t_guard = ($urandom_range(0, 2) == 0) ? 4'b1111 : 4'($urandom);
            if ($urandom_range(0, 39) == 0) do_reset();
            else tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
